// File: rtl/ikbd_pkg.sv
// Shared definitions for the IKBD key matrix transmitter: matrix geometry,
// key code layout and transmitter states.
package ikbd_pkg;

  localparam int KEY_ROWS        = 15;
  localparam int KEY_COLS        = 8;
  localparam int KEY_COUNT       = 120;
  localparam int DEFAULT_CLK_DIV = 256;

  // bit 7 = break (key released), bits 6:0 = scan index
  typedef logic [7:0] key_code_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  function automatic key_code_t make_code(input logic brk, input logic [6:0] idx);
    return {brk, idx};
  endfunction

endpackage

// File: rtl/ikbd_uart_tx.sv
// 8N1 serial transmitter with a valid/ready byte input; accepts a byte only
// in IDLE. The last stop-bit cycle is spent in IDLE so frames can abut.
module ikbd_uart_tx
  import ikbd_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      valid,
  input  key_code_t data,
  output logic      ready,
  output logic      tx,
  output logic      tx_busy
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(CLK_DIV - 2);

  tx_state_t       state_r, state_s;
  logic [CW-1:0]   baud_r, baud_s;
  logic [2:0]      bit_r, bit_s;
  key_code_t       shift_r, shift_s;
  logic            tx_r, tx_s;
  logic            busy_r, busy_s;

  assign ready   = (state_r == IDLE);
  assign tx      = tx_r;
  assign tx_busy = busy_r;

  // Next-state, counters and the line level for the coming cycle
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    case (state_r)
      IDLE: begin
        baud_s = '0;
        bit_s  = 3'd0;
        if (valid) begin
          shift_s = data;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (baud_r == BAUD_LAST) begin
          baud_s  = '0;
          state_s = DATA;
        end else begin
          baud_s = baud_r + 1'b1;
        end
      end
      DATA: begin
        if (baud_r == BAUD_LAST) begin
          baud_s  = '0;
          shift_s = {1'b1, shift_r[7:1]};
          if (bit_r == 3'd7) begin
            bit_s   = 3'd0;
            state_s = STOP;
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          baud_s = baud_r + 1'b1;
        end
      end
      STOP: begin
        if (baud_r == STOP_LAST) begin
          baud_s  = '0;
          state_s = IDLE;
        end else begin
          baud_s = baud_r + 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
    // the IDLE cycle right after STOP still carries the stop bit
    busy_s = (state_s != IDLE) || (state_r == STOP);
  end

  // Transmitter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      baud_r  <= '0;
      bit_r   <= 3'd0;
      shift_r <= 8'hFF;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      busy_r  <= busy_s;
    end
  end

endmodule

// File: rtl/ikbd_matrix_tx.sv
// Scans the 15x8 active-low key matrix, queues make/break codes and sends them
// as 8N1 frames. Define MATRIX_FILTER_EN for one-scan debounce per key.
module ikbd_matrix_tx
  import ikbd_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  matrix [KEY_ROWS],
  output logic                        tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [6:0]  IDX_LAST  = 7'(KEY_COUNT - 1);
  localparam logic [AW:0] FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  logic [6:0]           idx_r, idx_s;
  logic [KEY_COUNT-1:0] image_r;
  logic                 cur_s, prev_s, diff_s, report_s;
  logic                 full_s, push_s, stall_s, pop_s, valid_s, ready_s;
  key_code_t            code_s, head_s;
  key_code_t            mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [AW:0]          count_r;
`ifdef MATRIX_FILTER_EN
  logic [KEY_COUNT-1:0] pending_r;
`endif

  assign cur_s      = matrix[idx_r[6:3]][idx_r[2:0]];
  assign prev_s     = image_r[idx_r];
  assign code_s     = make_code(cur_s, idx_r);
  assign valid_s    = (count_r != '0);
  assign pop_s      = valid_s && ready_s;
  assign head_s     = mem_r[rd_ptr_r];
  assign fifo_level = count_r;

  // Change detection; a full FIFO freezes the scanner so nothing is lost
  always_comb begin
    diff_s = (cur_s != prev_s);
`ifdef MATRIX_FILTER_EN
    report_s = diff_s && pending_r[idx_r];
`else
    report_s = diff_s;
`endif
    full_s  = (count_r == FIFO_FULL);
    push_s  = report_s && !full_s;
    stall_s = report_s && full_s;
    if (stall_s) begin
      idx_s = idx_r;
    end else if (idx_r == IDX_LAST) begin
      idx_s = 7'd0;
    end else begin
      idx_s = idx_r + 7'd1;
    end
  end

  // Scan position and stored key image
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r   <= 7'd0;
      image_r <= '1;
    end else begin
      idx_r <= idx_s;
      if (push_s) begin
        image_r[idx_r] <= cur_s;
      end
    end
  end

`ifdef MATRIX_FILTER_EN
  // A difference must be seen on two consecutive visits to be reported
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r <= '0;
    end else if (!diff_s) begin
      pending_r[idx_r] <= 1'b0;
    end else if (!pending_r[idx_r]) begin
      pending_r[idx_r] <= 1'b1;
    end else if (push_s) begin
      pending_r[idx_r] <= 1'b0;
    end
  end
`endif

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= code_s;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  ikbd_uart_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_uart_tx (
    .clk     (clk),
    .reset   (reset),
    .valid   (valid_s),
    .data    (head_s),
    .ready   (ready_s),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

endmodule

// File: tb/tb_ikbd_matrix_tx.sv
// Scoreboard bench for ikbd_matrix_tx: expected codes are queued as the matrix
// is driven and checked against frames decoded from tx.
module tb_ikbd_matrix_tx;

  localparam int TB_DIV    = 4;
  localparam int FRAME_LEN = 10 * TB_DIV;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] matrix [15];
  logic       tx;
  logic       tx_busy;
  logic [3:0] fifo_level;

  ikbd_matrix_tx #(
    .CLK_DIV    (TB_DIV),
    .FIFO_DEPTH (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .matrix     (matrix),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int         checks    = 0;
  int         failures  = 0;
  logic [7:0] sb_q[$];
  int         cyc       = 0;
  bit         in_frame  = 1'b0;
  int         fcnt      = 0;
  logic [9:0] fbits;
  int         glitch    = 0;
  int         spurious  = 0;
  int         frames    = 0;
  int         last_start = 0;
  bit         have_prev = 1'b0;
  bit         check_gap = 1'b0;
  int         max_level = 0;
  logic [7:0] exp_code;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: frames start on a low tx, bits are TB_DIV cycles wide
  always @(negedge clk) begin
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    if (reset) begin
      in_frame = 1'b0;
      sb_q.delete();
    end else begin
      if (!in_frame && tx == 1'b0) begin
        in_frame = 1'b1;
        fcnt     = 0;
        glitch   = 0;
        fbits    = '0;
        if (check_gap && have_prev) check_eq("gap", cyc - last_start, FRAME_LEN);
        have_prev  = 1'b1;
        last_start = cyc;
      end
      if (in_frame) begin
        if (fcnt % TB_DIV == 0) fbits[fcnt / TB_DIV] = tx;
        else if (tx !== fbits[fcnt / TB_DIV]) glitch++;
        fcnt++;
        if (fcnt == FRAME_LEN) begin
          in_frame = 1'b0;
          frames++;
          if (sb_q.size() == 0) begin
            spurious++;
          end else begin
            exp_code = sb_q.pop_front();
            check_eq("frame", fbits, {1'b1, exp_code, 1'b0});
            check_eq("bit_stable", glitch, 0);
          end
        end
      end
    end
  end

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (sb_q.size() == 0 && !in_frame && !tx_busy && fifo_level == 4'd0) break;
    end
    check_eq(tag, sb_q.size(), 0);
  endtask

  task automatic reset_with(input logic [7:0] fill);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int r = 0; r < 15; r++) matrix[r] = fill;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int lat;
    int chg;
    int frames0;

    for (int r = 0; r < 15; r++) matrix[r] = 8'hFF;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_eq("rst_tx", tx, 1);
    check_eq("rst_busy", tx_busy, 0);
    check_eq("rst_level", fifo_level, 0);

    // all keys released: line stays idle
    repeat (2000) @(posedge clk);
    #2;
    check_eq("idle_tx", tx, 1);
    check_eq("idle_busy", tx_busy, 0);
    check_eq("idle_level", fifo_level, 0);
    check_eq("idle_frames", frames, 0);
    check_eq("idle_in_frame", in_frame, 0);

    // single make then break of idx 37
    @(posedge clk); #1;
    chg = cyc;
    matrix[4][5] = 1'b0;
    sb_q.push_back(8'h25);
    wait_drain("drain_make37", 600);
    lat = last_start - chg;
`ifndef MATRIX_FILTER_EN
    check_eq("latency_make37", lat <= 122, 1);
`endif
    @(posedge clk); #1;
    matrix[4][5] = 1'b1;
    sb_q.push_back(8'hA5);
    wait_drain("drain_break37", 600);
    check_eq("single_frames", frames, 2);

    // reset during data bit 3 of 0x25 aborts the frame
    @(posedge clk); #1;
    matrix[4][5] = 1'b0;
    sb_q.push_back(8'h25);
    for (int i = 0; i < 400 && !in_frame; i++) begin
      @(posedge clk); #2;
    end
    check_eq("rst_frame_started", in_frame, 1);
    repeat (16) @(posedge clk);
    #1;
    check_eq("rst_bit3_low", tx, 0);
    reset = 1'b1;
    matrix[4][5] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("rst_mid_tx", tx, 1);
    check_eq("rst_mid_level", fifo_level, 0);
    check_eq("rst_mid_busy", tx_busy, 0);
    frames0 = frames;
    repeat (300) @(posedge clk);
    #2;
    check_eq("rst_no_frames", frames - frames0, 0);
    check_eq("rst_queue", sb_q.size(), 0);

    // every key pressed at once: 120 back-to-back makes in scan order
    reset_with(8'h00);
    for (int k = 0; k < 120; k++) sb_q.push_back(8'(k));
    check_gap = 1'b1;
    have_prev = 1'b0;
    max_level = 0;
    frames0   = frames;
    wait_drain("drain_burst", 8000);
    check_gap = 1'b0;
    check_eq("burst_frames", frames - frames0, 120);
    check_eq("burst_max_level", max_level, 8);

    reset_with(8'hFF);
    repeat (200) @(posedge clk);
    #2;
    check_eq("post_burst_level", fifo_level, 0);

`ifdef MATRIX_FILTER_EN
    // short glitch is filtered, held press and release are reported once
    frames0 = frames;
    @(posedge clk); #1;
    matrix[0][4] = 1'b0;
    repeat (50) @(posedge clk);
    #1 matrix[0][4] = 1'b1;
    repeat (300) @(posedge clk);
    #2;
    check_eq("filter_glitch", frames - frames0, 0);
    @(posedge clk); #1;
    matrix[0][4] = 1'b0;
    sb_q.push_back(8'h04);
    repeat (300) @(posedge clk);
    wait_drain("drain_filter_make", 600);
    @(posedge clk); #1;
    matrix[0][4] = 1'b1;
    sb_q.push_back(8'h84);
    wait_drain("drain_filter_break", 600);
    repeat (300) @(posedge clk);
    #2;
    check_eq("filter_frames", frames - frames0, 2);
`endif

    check_eq("spurious_frames", spurious, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
